// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, D-stage redirect controls
// and the F/D pipeline register outputs.
interface pc_fetch_unit_if;
    // Redirect and hazard controls from the D stage / hazard unit
    logic        stall_i;
    logic [1:0]  npc_sel_i;
    logic [15:0] branch_off_i;
    logic [25:0] jump_idx_i;
    logic [31:0] jr_target_i;
    // Instruction memory read port
    logic [31:0] instr_f_i;
    logic [31:0] pc_f_o;
    // F/D pipeline register
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc8_d_o;
    logic        adel_d_o;

    // The fetch unit itself
    modport master (
        input  stall_i,
        input  npc_sel_i,
        input  branch_off_i,
        input  jump_idx_i,
        input  jr_target_i,
        input  instr_f_i,
        output pc_f_o,
        output instr_d_o,
        output pc_d_o,
        output pc8_d_o,
        output adel_d_o
    );

    // Surrounding pipeline and instruction memory
    modport slave (
        output stall_i,
        output npc_sel_i,
        output branch_off_i,
        output jump_idx_i,
        output jr_target_i,
        output instr_f_i,
        input  pc_f_o,
        input  instr_d_o,
        input  pc_d_o,
        input  pc8_d_o,
        input  adel_d_o
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage of the P5 MIPS pipeline: holds the F-stage PC, selects the
// next PC (sequential / branch / jump / register) and owns the F/D register.
// Redirect targets are based on the D-stage PC so the delay slot always runs.
module pc_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_MIN   = 32'h0000_3000,
    parameter logic [31:0] PC_MAX   = 32'h0000_6ffc
) (
    input logic              clk,
    input logic              reset,
    pc_fetch_unit_if.master  bus
);

    localparam logic [1:0] SelSeq    = 2'd0;
    localparam logic [1:0] SelBranch = 2'd1;
    localparam logic [1:0] SelJump   = 2'd2;
    localparam logic [1:0] SelJr     = 2'd3;

    localparam logic [31:0] Nop = 32'h0000_0000;

    logic [31:0] pc_q;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q;
    logic [31:0] pc8_d_q;
    logic        adel_d_q;

    logic [31:0] npc;
    logic [31:0] pc_plus4;
    logic [31:0] br_off_ext;
    logic        fetch_bad;

    assign pc_plus4   = pc_q + 32'd4;
    assign br_off_ext = {{14{bus.branch_off_i[15]}}, bus.branch_off_i, 2'b00};

    // Next-PC mux; targets use the D-stage PC, not the fetch PC
    always_comb begin
        npc = pc_plus4;
        unique case (bus.npc_sel_i)
            SelSeq:    npc = pc_plus4;
            SelBranch: npc = pc_d_q + 32'd4 + br_off_ext;
            SelJump:   npc = {pc_d_q[31:28], bus.jump_idx_i, 2'b00};
            SelJr:     npc = bus.jr_target_i;
            default:   npc = pc_plus4;
        endcase
    end

    // Misaligned or outside instruction memory: squash to nop and flag AdEL
    always_comb begin
        fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < PC_MIN) || (pc_q > PC_MAX);
        instr_d_d = fetch_bad ? Nop : bus.instr_f_i;
    end

    // PC and F/D register; stall freezes both and discards the redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= PC_RESET;
            instr_d_q <= Nop;
            pc_d_q    <= PC_RESET;
            pc8_d_q   <= PC_RESET + 32'd8;
            adel_d_q  <= 1'b0;
        end else if (!bus.stall_i) begin
            pc_q      <= npc;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_q;
            pc8_d_q   <= pc_q + 32'd8;
            adel_d_q  <= fetch_bad;
        end
    end

    assign bus.pc_f_o    = pc_q;
    assign bus.instr_d_o = instr_d_q;
    assign bus.pc_d_o    = pc_d_q;
    assign bus.pc8_d_o   = pc8_d_q;
    assign bus.adel_d_o  = adel_d_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: table of redirect/stall vectors with expected PCs,
// results queued per step and compared after each clock edge.
module tb_pc_fetch_unit;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic [15:0] off;
        logic [25:0] idx;
        logic [31:0] jr;
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic        adel;
    } vec_t;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr;
        logic [31:0] pc_d;
        logic [31:0] pc8;
        logic        adel;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   step;
    exp_t sb[$];
    vec_t vecs[$];

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: distinct word per address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9e37_79b9) ^ 32'h1234_5678;
    endfunction

    always_comb bus.instr_f_i = mem(bus.pc_f_o);

    function automatic vec_t v(input logic st, input logic [1:0] sel, input logic [15:0] off,
                               input logic [25:0] idx, input logic [31:0] jr,
                               input logic [31:0] pcf, input logic [31:0] pcd,
                               input logic adel);
        vec_t r;
        r.stall = st; r.sel = sel; r.off = off; r.idx = idx; r.jr = jr;
        r.pc_f = pcf; r.pc_d = pcd; r.adel = adel;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s step %0d: got %h, want %h", name, step, act, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pcf, input logic [31:0] pcd, input logic adel,
                            input logic [31:0] instr);
        exp_t e;
        e.pc_f = pcf; e.pc_d = pcd; e.pc8 = pcd + 32'd8; e.adel = adel; e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard step %0d: got empty queue, want entry", step);
            return;
        end
        e = sb.pop_front();
        cmp("pc_f", bus.pc_f_o, e.pc_f);
        cmp("instr_d", bus.instr_d_o, e.instr);
        cmp("pc_d", bus.pc_d_o, e.pc_d);
        cmp("pc8_d", bus.pc8_d_o, e.pc8);
        cmp("adel_d", {31'd0, bus.adel_d_o}, {31'd0, e.adel});
    endtask

    // Drive one vector, push its expectation, clock once, compare
    task automatic apply(input vec_t x);
        bus.stall_i      = x.stall;
        bus.npc_sel_i    = x.sel;
        bus.branch_off_i = x.off;
        bus.jump_idx_i   = x.idx;
        bus.jr_target_i  = x.jr;
        push_exp(x.pc_f, x.pc_d, x.adel, x.adel ? 32'h0 : mem(x.pc_d));
        @(posedge clk);
        #1;
        pop_check();
        step++;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        step  = 0;

        // Sequential run from reset
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3004, 32'h3000, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3008, 32'h3004, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h300c, 32'h3008, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3010, 32'h300c, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3014, 32'h3010, 0));
        // Backward branch from pc_d=3010; delay slot 3014 enters D
        vecs.push_back(v(0, 1, 16'hfffc, 26'h0,     32'h0,         32'h3004, 32'h3014, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3008, 32'h3004, 0));
        // j and jr
        vecs.push_back(v(0, 2, 16'h0,    26'h0c40,  32'h0,         32'h3100, 32'h3008, 0));
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'h3200,      32'h3200, 32'h3100, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3204, 32'h3200, 0));
        // Stall with branch pending holds everything; branch taken after
        vecs.push_back(v(1, 1, 16'h0010, 26'h0,     32'h0,         32'h3204, 32'h3200, 0));
        vecs.push_back(v(1, 1, 16'h0010, 26'h0,     32'h0,         32'h3204, 32'h3200, 0));
        vecs.push_back(v(0, 1, 16'h0010, 26'h0,     32'h0,         32'h3244, 32'h3204, 0));
        // Bad jr targets: misaligned, above max, below min
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'h3002,      32'h3002, 32'h3244, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3006, 32'h3002, 1));
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'h7000,      32'h7000, 32'h3006, 1));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h7004, 32'h7000, 1));
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'h2ffc,      32'h2ffc, 32'h7004, 1));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h3000, 32'h2ffc, 1));
        // Last legal word, then just past it
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'h6ffc,      32'h6ffc, 32'h3000, 0));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h7000, 32'h6ffc, 0));
        // Wrap modulo 2^32
        vecs.push_back(v(0, 3, 16'h0,    26'h0,     32'hffff_fffc, 32'hffff_fffc, 32'h7000, 1));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h0000_0000, 32'hffff_fffc, 1));
        vecs.push_back(v(0, 0, 16'h0,    26'h0,     32'h0,         32'h0000_0004, 32'h0, 1));
        // Jump keeps pc_d[31:28] (0 here), then stall with jump pending
        vecs.push_back(v(0, 2, 16'h0,    26'h0d00,  32'h0,         32'h3400, 32'h4, 1));
        vecs.push_back(v(1, 2, 16'h0,    26'h0c40,  32'h0,         32'h3400, 32'h4, 1));

        bus.stall_i      = 1'b0;
        bus.npc_sel_i    = 2'd0;
        bus.branch_off_i = 16'h0;
        bus.jump_idx_i   = 26'h0;
        bus.jr_target_i  = 32'h0;

        // Reset held for three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp(32'h3000, 32'h3000, 1'b0, 32'h0);
        pop_check();
        step++;
        reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset between edges while pc_f=3400 and stalled
        bus.stall_i   = 1'b1;
        bus.npc_sel_i = 2'd1;
        #3;
        reset = 1'b0;
        #1;
        push_exp(32'h3000, 32'h3000, 1'b0, 32'h0);
        pop_check();
        step++;
        #2;
        reset = 1'b1;

        // Restart after mid-cycle reset
        apply(v(0, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 0));
        apply(v(0, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
